drive_ctrl: RTL and testbench
=============================

DRIVE_CTRL -- requirements
Module: drive_ctrl

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- STOP_CM, 20: obstacle distance (cm) below which the car stops.
- GO_CM, 30: distance (cm) at or above which the car resumes; GO_CM > STOP_CM.
- DEB_CYC, 16: cycles a track input must be stable before its filtered value changes.
- LOST_CYC, 50_000_000: cycles allowed in SEARCH before giving up.
- SONIC_TO, 10_000_000: max cycles between dist_valid pulses before fail-safe.
REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1: system clock.
- rst, in, 1: asynchronous, active-high reset.
- distance, in, 20: ultrasonic distance in cm, unsigned.
- dist_valid, in, 1: one-cycle pulse; distance is valid in that cycle.
- left_track / mid_track / right_track, in, 1 each: asynchronous line sensors; 1 = line under sensor.
- mode, out, 2: motor command; 00 stop, 01 turn left, 10 turn right, 11 forward.
- state_dbg, out, 3: current FSM state encoding.
- nums, out, 16: four BCD digits of the last displayed distance, [15:12] thousands ... [3:0] units.

Function
REQ-003 Each track input SHALL pass a 2-FF synchronizer and then a debouncer. The filtered bit takes the synchronized value only after DEB_CYC consecutive equal samples that differ from the current filtered value.
REQ-004 The filtered pattern {L,M,R} SHALL decode as follows:
- 010, 111, 101 -> forward.
- 100, 110 -> left.
- 001, 011 -> right.
- 000 -> lost.
REQ-005 blocked SHALL set when dist_valid=1 and distance < STOP_CM.
REQ-006 blocked SHALL clear when dist_valid=1 and distance >= GO_CM.
REQ-007 blocked SHALL hold for distances in [STOP_CM, GO_CM-1] (hysteresis).
REQ-008 A watchdog SHALL count cycles since the last dist_valid. When the count reaches SONIC_TO, blocked SHALL set. The counter reloads on every dist_valid.
REQ-009 The FSM SHALL have these states: FWD=0, LEFT=1, RIGHT=2, SEARCH=3, HALT=4, BLOCKED=5.
REQ-010 From any state, blocked=1 SHALL force BLOCKED on the next edge; this has the highest priority.
REQ-011 In BLOCKED with blocked=0, the next state SHALL follow the REQ-004 decode; a lost decode leads to SEARCH.
REQ-012 In FWD, LEFT or RIGHT, the next state SHALL be per the decode; a lost decode leads to SEARCH and clears the lost counter.
REQ-013 In SEARCH:
- mode SHALL turn in last_dir.
- The lost counter increments every cycle.
- Any non-lost decode SHALL exit to the decoded state.
- The counter reaching LOST_CYC-1 SHALL lead to HALT.
REQ-014 HALT SHALL remain until a non-lost decode, then go to the decoded state.
REQ-015 last_dir SHALL update to left on entering LEFT and to right on entering RIGHT; it is unchanged otherwise.
REQ-016 The lost counter SHALL freeze while in BLOCKED and SHALL not be cleared by it.
REQ-017 mode SHALL be registered and update on the same edge as the state:
- FWD -> 11.
- LEFT -> 01.
- RIGHT -> 10.
- SEARCH -> 01 or 10 per last_dir.
- HALT and BLOCKED -> 00.
REQ-018 Latency from a filtered pattern change to the mode change SHALL be 1 cycle.
REQ-019 On dist_valid while the converter is idle, the block SHALL latch min(distance, 9999) and run a sequential 14-bit double-dabble, one shift per cycle.
REQ-020 nums SHALL update atomically exactly 15 cycles after the accepted dist_valid.
REQ-021 A dist_valid arriving during a conversion SHALL be ignored by the converter but SHALL still be used by REQ-005 to REQ-008.
REQ-022 distance values >= 9999 SHALL display as 9999.

Reset
REQ-023 While rst=1, the block SHALL hold these values:
- state BLOCKED; mode 00; state_dbg 5.
- blocked=1; last_dir=left.
- filtered pattern 000; synchronizers and debounce counters 0.
- lost, watchdog and converter counters 0; converter idle.
- nums 16'h0000.
REQ-024 After reset, the block SHALL stay in BLOCKED until the first dist_valid with distance >= GO_CM.
REQ-025 Asserting rst mid-conversion or mid-SEARCH SHALL abort the operation immediately; no partial nums update is allowed.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- Reset, then dist_valid with distance=50 while pattern=010 is stable for more than DEB_CYC+2 cycles -> mode=11; nums=0050 after 15 cycles.
- Pattern 010 -> 110 stable -> mode=01 one cycle after the filtered change; a 5-cycle glitch to 001 -> mode unchanged.
- Distance sequence 25, 19, 25, 30 -> blocked after 19 (mode=00); still 00 at 25; resumes at 30.
- Pattern 000 after last_dir=right -> mode=10 for LOST_CYC cycles (reduced parameter), then HALT with mode=00; pattern 010 -> mode=11.
- No dist_valid for SONIC_TO cycles while in FWD -> BLOCKED, mode=00; distance=40 -> resume.
- distance=123456 -> nums=9999; a second dist_valid 3 cycles later -> ignored by the display, nums stays 9999.

Source files
------------

// File: rtl/drive_ctrl.sv
// drive_ctrl: line-following car controller.
// Filters three line sensors, tracks obstacle distance with hysteresis and a
// sensor-silence watchdog, steers via a six-state FSM, and converts the last
// accepted distance to four BCD digits for a display.
module drive_ctrl #(
    parameter int STOP_CM  = 20,
    parameter int GO_CM    = 30,
    parameter int DEB_CYC  = 16,
    parameter int LOST_CYC = 50_000_000,
    parameter int SONIC_TO = 10_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] distance,
    input  logic        dist_valid,
    input  logic        left_track,
    input  logic        mid_track,
    input  logic        right_track,
    output logic [1:0]  mode,
    output logic [2:0]  state_dbg,
    output logic [15:0] nums
);

    localparam int DB_W   = $clog2(DEB_CYC + 1);
    localparam int LOST_W = $clog2(LOST_CYC + 1);
    localparam int WD_W   = $clog2(SONIC_TO + 1);

    localparam logic [DB_W-1:0]   DB_ZERO   = DB_W'(1'b0);
    localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1'b1);
    localparam logic [DB_W-1:0]   DEB_LAST  = DB_W'(DEB_CYC - 1);
    localparam logic [LOST_W-1:0] LOST_ZERO = LOST_W'(1'b0);
    localparam logic [LOST_W-1:0] LOST_ONE  = LOST_W'(1'b1);
    localparam logic [LOST_W-1:0] LOST_LAST = LOST_W'(LOST_CYC - 1);
    localparam logic [WD_W-1:0]   WD_ZERO   = WD_W'(1'b0);
    localparam logic [WD_W-1:0]   WD_ONE    = WD_W'(1'b1);
    localparam logic [WD_W-1:0]   WD_LIMIT  = WD_W'(SONIC_TO);

    localparam logic [19:0] STOP_D   = 20'(STOP_CM);
    localparam logic [19:0] GO_D     = 20'(GO_CM);
    localparam logic [19:0] DISP_MAX = 20'd9999;
    localparam logic [13:0] DISP_CAP = 14'd9999;

    localparam logic [1:0] MODE_STOP  = 2'b00;
    localparam logic [1:0] MODE_LEFT  = 2'b01;
    localparam logic [1:0] MODE_RIGHT = 2'b10;
    localparam logic [1:0] MODE_FWD   = 2'b11;

    typedef enum logic [2:0] {
        ST_FWD     = 3'd0,
        ST_LEFT    = 3'd1,
        ST_RIGHT   = 3'd2,
        ST_SEARCH  = 3'd3,
        ST_HALT    = 3'd4,
        ST_BLOCKED = 3'd5
    } state_t;

    // One double-dabble correction: every BCD digit of 5 or more gets +3
    function automatic logic [15:0] bcd_adjust(input logic [15:0] bcd);
        logic [15:0] res;
        res = bcd;
        for (int d = 0; d < 4; d++) begin
            if (res[4*d +: 4] >= 4'd5) begin
                res[4*d +: 4] = res[4*d +: 4] + 4'd3;
            end else begin
                res[4*d +: 4] = res[4*d +: 4];
            end
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Line sensor conditioning
    // ------------------------------------------------------------------
    logic [2:0]      track_s;
    logic [2:0]      sync1_r;
    logic [2:0]      sync2_r;
    logic [2:0]      filt_r;
    logic [DB_W-1:0] deb_cnt_r [3];

    assign track_s = {left_track, mid_track, right_track};

    // Two-flop synchronizer for the asynchronous line sensors
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 3'b000;
            sync2_r <= 3'b000;
        end else begin
            sync1_r <= track_s;
            sync2_r <= sync1_r;
        end
    end

    // Debounce: a filtered bit flips only after DEB_CYC consecutive differing samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_r <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                deb_cnt_r[i] <= DB_ZERO;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync2_r[i] == filt_r[i]) begin
                    deb_cnt_r[i] <= DB_ZERO;
                end else if (deb_cnt_r[i] == DEB_LAST) begin
                    filt_r[i]    <= sync2_r[i];
                    deb_cnt_r[i] <= DB_ZERO;
                end else begin
                    deb_cnt_r[i] <= deb_cnt_r[i] + DB_ONE;
                end
            end
        end
    end

    state_t dec_state_s;
    logic   dec_lost_s;

    // Map the filtered {L,M,R} pattern onto a steering target
    always_comb begin
        dec_state_s = ST_SEARCH;
        dec_lost_s  = 1'b1;
        case (filt_r)
            3'b010, 3'b111, 3'b101: begin
                dec_state_s = ST_FWD;
                dec_lost_s  = 1'b0;
            end
            3'b100, 3'b110: begin
                dec_state_s = ST_LEFT;
                dec_lost_s  = 1'b0;
            end
            3'b001, 3'b011: begin
                dec_state_s = ST_RIGHT;
                dec_lost_s  = 1'b0;
            end
            default: begin
                dec_state_s = ST_SEARCH;
                dec_lost_s  = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Obstacle flag and ultrasonic watchdog
    // ------------------------------------------------------------------
    logic            blocked_r;
    logic [WD_W-1:0] wd_cnt_r;

    // Obstacle flag with hysteresis, forced on when the sensor goes silent
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blocked_r <= 1'b1;
            wd_cnt_r  <= WD_ZERO;
        end else if (dist_valid) begin
            wd_cnt_r <= WD_ZERO;
            if (distance < STOP_D) begin
                blocked_r <= 1'b1;
            end else if (distance >= GO_D) begin
                blocked_r <= 1'b0;
            end else begin
                blocked_r <= blocked_r;
            end
        end else if (wd_cnt_r == WD_LIMIT) begin
            blocked_r <= 1'b1;
        end else begin
            wd_cnt_r <= wd_cnt_r + WD_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Steering FSM
    // ------------------------------------------------------------------
    state_t              state_r;
    state_t              next_state_s;
    logic [LOST_W-1:0]   lost_cnt_r;
    logic                last_dir_r;   // 0 = left, 1 = right
    logic [1:0]          mode_next_s;
    logic [1:0]          mode_r;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_BLOCKED;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next state: obstacle first, then a valid line, then lost-line handling
    always_comb begin
        next_state_s = state_r;
        if (blocked_r) begin
            next_state_s = ST_BLOCKED;
        end else if (!dec_lost_s) begin
            next_state_s = dec_state_s;
        end else begin
            case (state_r)
                ST_SEARCH: begin
                    if (lost_cnt_r == LOST_LAST) begin
                        next_state_s = ST_HALT;
                    end else begin
                        next_state_s = ST_SEARCH;
                    end
                end
                ST_HALT: next_state_s = ST_HALT;
                default: next_state_s = ST_SEARCH;
            endcase
        end
    end

    // Lost-line timer: runs in SEARCH, restarts when a tracking state loses the line, frozen elsewhere
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lost_cnt_r <= LOST_ZERO;
        end else begin
            case (state_r)
                ST_SEARCH: begin
                    if (lost_cnt_r == LOST_LAST) begin
                        lost_cnt_r <= lost_cnt_r;
                    end else begin
                        lost_cnt_r <= lost_cnt_r + LOST_ONE;
                    end
                end
                ST_FWD, ST_LEFT, ST_RIGHT: begin
                    if (next_state_s == ST_SEARCH) begin
                        lost_cnt_r <= LOST_ZERO;
                    end else begin
                        lost_cnt_r <= lost_cnt_r;
                    end
                end
                default: lost_cnt_r <= lost_cnt_r;
            endcase
        end
    end

    // Remember the last turn direction so SEARCH sweeps the same way
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_dir_r <= 1'b0;
        end else if (next_state_s == ST_LEFT) begin
            last_dir_r <= 1'b0;
        end else if (next_state_s == ST_RIGHT) begin
            last_dir_r <= 1'b1;
        end else begin
            last_dir_r <= last_dir_r;
        end
    end

    // Motor command for the state being entered
    always_comb begin
        mode_next_s = MODE_STOP;
        case (next_state_s)
            ST_FWD:   mode_next_s = MODE_FWD;
            ST_LEFT:  mode_next_s = MODE_LEFT;
            ST_RIGHT: mode_next_s = MODE_RIGHT;
            ST_SEARCH: begin
                if (last_dir_r) begin
                    mode_next_s = MODE_RIGHT;
                end else begin
                    mode_next_s = MODE_LEFT;
                end
            end
            default:  mode_next_s = MODE_STOP;
        endcase
    end

    // Motor command register, updated on the same edge as the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_r <= MODE_STOP;
        end else begin
            mode_r <= mode_next_s;
        end
    end

    // ------------------------------------------------------------------
    // Distance display: sequential double-dabble
    // ------------------------------------------------------------------
    logic        conv_busy_r;
    logic [3:0]  conv_step_r;
    logic [13:0] conv_bin_r;
    logic [15:0] conv_bcd_r;
    logic [15:0] nums_r;
    logic [13:0] disp_val_s;
    logic [15:0] bcd_adj_s;

    assign disp_val_s = (distance >= DISP_MAX) ? DISP_CAP : distance[13:0];
    assign bcd_adj_s  = bcd_adjust(conv_bcd_r);

    // Latch a new distance when idle, shift once per cycle, publish all digits at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conv_busy_r <= 1'b0;
            conv_step_r <= 4'd0;
            conv_bin_r  <= 14'd0;
            conv_bcd_r  <= 16'h0000;
            nums_r      <= 16'h0000;
        end else if (conv_busy_r) begin
            if (conv_step_r == 4'd14) begin
                nums_r      <= conv_bcd_r;
                conv_busy_r <= 1'b0;
                conv_step_r <= 4'd0;
            end else begin
                conv_bcd_r  <= {bcd_adj_s[14:0], conv_bin_r[13]};
                conv_bin_r  <= {conv_bin_r[12:0], 1'b0};
                conv_step_r <= conv_step_r + 4'd1;
            end
        end else if (dist_valid) begin
            conv_bin_r  <= disp_val_s;
            conv_bcd_r  <= 16'h0000;
            conv_step_r <= 4'd0;
            conv_busy_r <= 1'b1;
        end else begin
            conv_busy_r <= 1'b0;
        end
    end

    assign mode      = mode_r;
    assign state_dbg = state_r;
    assign nums      = nums_r;

endmodule

// File: tb/tb_drive_ctrl.sv
// Testbench for drive_ctrl: directed scenarios plus randomized traffic, all
// compared every cycle against a behavioural reference model.
module tb_drive_ctrl;

    localparam int T_STOP  = 20;
    localparam int T_GO    = 30;
    localparam int T_DEB   = 8;
    localparam int T_LOST  = 40;
    localparam int T_SONIC = 300;

    logic        clk;
    logic        rst;
    logic [19:0] distance;
    logic        dist_valid;
    logic        left_track;
    logic        mid_track;
    logic        right_track;
    logic [1:0]  mode;
    logic [2:0]  state_dbg;
    logic [15:0] nums;

    int n_tests = 0;
    int n_fail  = 0;

    drive_ctrl #(
        .STOP_CM  (T_STOP),
        .GO_CM    (T_GO),
        .DEB_CYC  (T_DEB),
        .LOST_CYC (T_LOST),
        .SONIC_TO (T_SONIC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .distance    (distance),
        .dist_valid  (dist_valid),
        .left_track  (left_track),
        .mid_track   (mid_track),
        .right_track (right_track),
        .mode        (mode),
        .state_dbg   (state_dbg),
        .nums        (nums)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [2:0]             st;      // state number: 0 fwd .. 5 blocked
        logic                   blocked;
        logic [31:0]            lost;    // cycles spent searching
        logic                   dir_r;   // 1 = last turn was right
        logic [1:0]             mode;
        logic [2:0]             filt;
        logic [2:0]             raw1;
        logic [2:0]             raw2;
        logic [2:0][T_DEB-1:0]  hist;    // synchronized samples, bit 0 newest
        logic [31:0]            since;   // cycles since last dist_valid
        logic                   busy;
        logic [31:0]            left;    // cycles until display update
        logic [31:0]            val;
        logic [15:0]            nums;
    } mdl_t;

    mdl_t m;

    function automatic int decode(input logic [2:0] p);
        case (p)
            3'b010, 3'b111, 3'b101: return 0;
            3'b100, 3'b110:         return 1;
            3'b001, 3'b011:         return 2;
            default:                return -1;
        endcase
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic mdl_t reset_model();
        mdl_t r;
        r = '0;
        r.st      = 3'd5;
        r.blocked = 1'b1;
        return r;
    endfunction

    function automatic mdl_t step(input mdl_t c, input logic [2:0] raw, input logic dv, input logic [19:0] d);
        mdl_t n;
        int tgt;
        logic [T_DEB-1:0] h;
        n = c;
        tgt = decode(c.filt);
        if (c.blocked) n.st = 3'd5;
        else if (tgt >= 0) n.st = 3'(tgt);
        else if (c.st == 3'd3) n.st = (c.lost >= 32'(T_LOST - 1)) ? 3'd4 : 3'd3;
        else if (c.st == 3'd4) n.st = 3'd4;
        else n.st = 3'd3;
        if (c.st == 3'd3) n.lost = c.lost + 32'd1;
        else if (c.st <= 3'd2 && n.st == 3'd3) n.lost = 32'd0;
        if (n.st == 3'd1) n.dir_r = 1'b0;
        else if (n.st == 3'd2) n.dir_r = 1'b1;
        case (n.st)
            3'd0: n.mode = 2'b11;
            3'd1: n.mode = 2'b01;
            3'd2: n.mode = 2'b10;
            3'd3: n.mode = n.dir_r ? 2'b10 : 2'b01;
            default: n.mode = 2'b00;
        endcase
        if (dv) begin
            if (d < 20'(T_STOP)) n.blocked = 1'b1;
            else if (d >= 20'(T_GO)) n.blocked = 1'b0;
        end else if (c.since >= 32'(T_SONIC)) begin
            n.blocked = 1'b1;
        end
        n.since = dv ? 32'd0 : c.since + 32'd1;
        for (int b = 0; b < 3; b++) begin
            h = {c.hist[b][T_DEB-2:0], c.raw2[b]};
            n.hist[b] = h;
            if (h == {T_DEB{~c.filt[b]}}) n.filt[b] = ~c.filt[b];
        end
        n.raw1 = raw;
        n.raw2 = c.raw1;
        if (c.busy) begin
            n.left = c.left - 32'd1;
            if (c.left == 32'd1) begin
                n.nums = to_bcd(int'(c.val));
                n.busy = 1'b0;
            end
        end else if (dv) begin
            n.val  = (d >= 20'd9999) ? 32'd9999 : 32'(d);
            n.busy = 1'b1;
            n.left = 32'd15;
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= reset_model();
        else m <= step(m, {left_track, mid_track, right_track}, dist_valid, distance);
    end

    always @(negedge clk) begin
        check_val("model_state", 32'(state_dbg), 32'(m.st));
        check_val("model_mode",  32'(mode),      32'(m.mode));
        check_val("model_nums",  32'(nums),      32'(m.nums));
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_pat(input logic [2:0] p);
        @(negedge clk);
        {left_track, mid_track, right_track} = p;
    endtask

    task automatic send_dist(input logic [19:0] d);
        @(negedge clk);
        distance   = d;
        dist_valid = 1'b1;
        @(negedge clk);
        dist_valid = 1'b0;
    endtask

    task automatic rst_on();
        @(negedge clk);
        #2 rst = 1'b1;
    endtask

    task automatic rst_off();
        @(negedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin
        int hold;
        rst = 1'b1;
        distance = 20'd0;
        dist_valid = 1'b0;
        {left_track, mid_track, right_track} = 3'b000;

        // reset state
        tick(3);
        check_val("rst_state", 32'(state_dbg), 32'd5);
        check_val("rst_mode",  32'(mode),      32'd0);
        check_val("rst_nums",  32'(nums),      32'h0000);
        rst_off();

        // S1: line centred, first good distance releases the car
        set_pat(3'b010);
        tick(T_DEB + 4);
        check_val("s1_wait_dist", 32'(mode), 32'd0);
        send_dist(20'd50);
        tick(1);
        check_val("s1_fwd", 32'(mode), 32'd3);
        tick(13);
        check_val("s1_nums_early", 32'(nums), 32'h0000);
        tick(1);
        check_val("s1_nums_15", 32'(nums), 32'h0050);

        // S2: drift left, then a short glitch that must be filtered
        set_pat(3'b110);
        tick(T_DEB + 2);
        check_val("s2_before", 32'(mode), 32'd3);
        tick(1);
        check_val("s2_left", 32'(mode), 32'd1);
        set_pat(3'b001);
        tick(4);
        set_pat(3'b110);
        tick(T_DEB + 5);
        check_val("s2_glitch", 32'(mode), 32'd1);

        // S3: hysteresis on distance
        set_pat(3'b010);
        tick(T_DEB + 4);
        send_dist(20'd25);
        tick(1);
        check_val("s3_25", 32'(mode), 32'd3);
        send_dist(20'd19);
        tick(1);
        check_val("s3_19", 32'(mode), 32'd0);
        send_dist(20'd25);
        tick(1);
        check_val("s3_25b", 32'(mode), 32'd0);
        send_dist(20'd30);
        tick(1);
        check_val("s3_30", 32'(mode), 32'd3);

        // S4: lose the line after a right turn, search, halt, recover
        set_pat(3'b011);
        tick(T_DEB + 4);
        check_val("s4_right", 32'(mode), 32'd2);
        send_dist(20'd50);
        set_pat(3'b000);
        tick(T_DEB + 3);
        check_val("s4_search_mode", 32'(mode), 32'd2);
        check_val("s4_search_st", 32'(state_dbg), 32'd3);
        tick(T_LOST - 1);
        check_val("s4_search_end", 32'(state_dbg), 32'd3);
        tick(1);
        check_val("s4_halt_st", 32'(state_dbg), 32'd4);
        check_val("s4_halt_mode", 32'(mode), 32'd0);
        send_dist(20'd50);
        set_pat(3'b010);
        tick(T_DEB + 3);
        check_val("s4_recover", 32'(mode), 32'd3);

        // S5: ultrasonic watchdog
        send_dist(20'd50);
        tick(T_SONIC + 1);
        check_val("s5_before_to", 32'(mode), 32'd3);
        tick(1);
        check_val("s5_timeout", 32'(mode), 32'd0);
        check_val("s5_timeout_st", 32'(state_dbg), 32'd5);
        send_dist(20'd40);
        tick(1);
        check_val("s5_resume", 32'(mode), 32'd3);

        // S6: saturated display and a dist_valid during conversion
        tick(20);
        send_dist(20'd123456);
        tick(1);
        send_dist(20'd100);
        tick(12);
        check_val("s6_9999", 32'(nums), 32'h9999);
        tick(20);
        check_val("s6_ignored", 32'(nums), 32'h9999);

        // Reset mid-conversion, then stay blocked until a far distance
        tick(5);
        send_dist(20'd77);
        tick(5);
        rst_on();
        tick(2);
        check_val("rc_nums", 32'(nums), 32'h0000);
        check_val("rc_state", 32'(state_dbg), 32'd5);
        rst_off();
        tick(20);
        check_val("rc_no_partial", 32'(nums), 32'h0000);
        check_val("rc_blocked", 32'(state_dbg), 32'd5);
        send_dist(20'd25);
        tick(1);
        check_val("rc_band", 32'(state_dbg), 32'd5);
        send_dist(20'd35);
        tick(1);
        check_val("rc_release", 32'(state_dbg), 32'd0);

        // Reset mid-SEARCH
        send_dist(20'd50);
        set_pat(3'b000);
        tick(T_DEB + 6);
        check_val("rs_search", 32'(state_dbg), 32'd3);
        rst_on();
        tick(1);
        check_val("rs_state", 32'(state_dbg), 32'd5);
        check_val("rs_mode", 32'(mode), 32'd0);
        rst_off();
        tick(3);
        check_val("rs_after", 32'(state_dbg), 32'd5);

        // Randomized traffic against the model
        hold = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (hold == 0) begin
                {left_track, mid_track, right_track} = 3'($urandom_range(0, 7));
                hold = ($urandom_range(0, 7) == 0) ? int'($urandom_range(40, 90)) : int'($urandom_range(1, 24));
            end else begin
                hold--;
            end
            if (((cyc / 500) % 3) == 2) dist_valid = ($urandom_range(0, 499) == 0);
            else dist_valid = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 9))
                0: distance = 20'($urandom_range(0, 1048575));
                1: distance = 20'($urandom_range(9990, 10010));
                default: distance = 20'($urandom_range(0, 45));
            endcase
            if (rst) begin
                #2 rst = 1'b0;
            end else if ($urandom_range(0, 999) == 0) begin
                #2 rst = 1'b1;
            end
        end
        dist_valid = 1'b0;
        rst = 1'b0;
        tick(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
